// File: rtl/ga_selection_unit.sv
// Fitness-proportionate / rank / tournament parent selection over a small fitness memory.
// Tournament mode is built only when GA_SEL_TOURNAMENT_EN is defined.
module ga_selection_unit #(
  parameter int unsigned FITNESS_WIDTH = 16,
  parameter int unsigned POP_SIZE      = 32,
  parameter int unsigned IDX_WIDTH     = $clog2(POP_SIZE),
  parameter int unsigned SUM_WIDTH     = FITNESS_WIDTH + IDX_WIDTH,
  parameter int unsigned TOUR_SIZE     = 4,
  parameter int unsigned RND_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [IDX_WIDTH-1:0]     wr_addr,
  input  logic [FITNESS_WIDTH-1:0] wr_data,
  input  logic                     prep_start,
  output logic                     prep_done,
  output logic [SUM_WIDTH-1:0]     total,
  input  logic                     req_vld,
  output logic                     req_rdy,
  input  logic [1:0]               req_mode,
  input  logic [RND_WIDTH-1:0]     req_rnd,
  output logic                     res_vld,
  input  logic                     res_rdy,
  output logic [IDX_WIDTH-1:0]     res_idx,
  output logic                     res_err
);

  typedef enum logic [2:0] {
    StIdle, StPrep, StReady, StTarget, StScan, StTour, StResp
  } state_e;

  localparam logic [1:0] ModeProp = 2'd0;
  localparam logic [1:0] ModeRank = 2'd1;
  localparam logic [1:0] ModeTour = 2'd2;

  localparam int unsigned        RankTotalInt = POP_SIZE * (POP_SIZE + 1) / 2;
  localparam logic [SUM_WIDTH-1:0] RankTotal  = SUM_WIDTH'(RankTotalInt);
  localparam logic [IDX_WIDTH-1:0] LastIdx    = IDX_WIDTH'(POP_SIZE - 1);

  logic [FITNESS_WIDTH-1:0] fit_mem [POP_SIZE];
  logic [SUM_WIDTH-1:0]     cum_f   [POP_SIZE];

  state_e                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   prep_idx_q, prep_idx_d;
  logic [SUM_WIDTH-1:0]   prep_sum_q, prep_sum_d;
  logic [SUM_WIDTH-1:0]   total_q, total_d;
  logic [1:0]             mode_q, mode_d;
  logic [RND_WIDTH-1:0]   rnd_q, rnd_d;
  logic [SUM_WIDTH-1:0]   target_q, target_d;
  logic [IDX_WIDTH-1:0]   scan_idx_q, scan_idx_d;
  logic [IDX_WIDTH-1:0]   res_idx_q, res_idx_d;
  logic                   res_err_q, res_err_d;

  logic                   wr_accept;
  logic                   mode_ok;
  logic [SUM_WIDTH-1:0]   prep_sum_next;
  logic [SUM_WIDTH-1:0]   w_total;
  logic [2*SUM_WIDTH-1:0] prod;
  logic [SUM_WIDTH-1:0]   cum_sel;
  logic                   unused_bits;

  // Rank prefix (i+1)(i+2)/2, evaluated at full product width to avoid wrap.
  function automatic logic [SUM_WIDTH-1:0] cum_r(input logic [IDX_WIDTH-1:0] i);
    logic [2*SUM_WIDTH-1:0] n;
    n = (2*SUM_WIDTH)'(i) + (2*SUM_WIDTH)'(1);
    return SUM_WIDTH'((n * (n + (2*SUM_WIDTH)'(1))) >> 1);
  endfunction

  assign wr_accept     = wr_en && (state_q == StIdle || state_q == StReady);
  assign prep_sum_next = prep_sum_q + SUM_WIDTH'(fit_mem[prep_idx_q]);
  assign w_total       = (mode_q == ModeRank) ? RankTotal : total_q;
  assign prod          = {{SUM_WIDTH{1'b0}}, rnd_q[SUM_WIDTH-1:0]} *
                         {{SUM_WIDTH{1'b0}}, w_total};
  assign cum_sel       = (mode_q == ModeRank) ? cum_r(scan_idx_q) : cum_f[scan_idx_q];
  assign unused_bits   = ^{rnd_q, prod[SUM_WIDTH-1:0]};

`ifdef GA_SEL_TOURNAMENT_EN
  localparam logic [2:0] LastTour = 3'(TOUR_SIZE - 1);

  logic [2:0]               tour_k_q, tour_k_d;
  logic [FITNESS_WIDTH-1:0] best_fit_q, best_fit_d;
  logic [IDX_WIDTH-1:0]     best_idx_q, best_idx_d;
  logic [IDX_WIDTH-1:0]     cand_idx;
  logic [FITNESS_WIDTH-1:0] cand_fit;
  logic                     cand_wins;

  assign cand_idx  = rnd_q[tour_k_q*IDX_WIDTH +: IDX_WIDTH];
  assign cand_fit  = fit_mem[cand_idx];
  // Strict compare keeps the earlier candidate on ties.
  assign cand_wins = (tour_k_q == 3'd0) || (cand_fit > best_fit_q);
  assign mode_ok   = (req_mode != 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tour_k_q   <= '0;
      best_fit_q <= '0;
      best_idx_q <= '0;
    end else begin
      tour_k_q   <= tour_k_d;
      best_fit_q <= best_fit_d;
      best_idx_q <= best_idx_d;
    end
  end
`else
  assign mode_ok = (req_mode == ModeProp) || (req_mode == ModeRank);
`endif

  // Fitness and prefix storage are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_accept) fit_mem[wr_addr] <= wr_data;
    if (state_q == StPrep) cum_f[prep_idx_q] <= prep_sum_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      prep_idx_q <= '0;
      prep_sum_q <= '0;
      total_q    <= '0;
      mode_q     <= '0;
      rnd_q      <= '0;
      target_q   <= '0;
      scan_idx_q <= '0;
      res_idx_q  <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prep_idx_q <= prep_idx_d;
      prep_sum_q <= prep_sum_d;
      total_q    <= total_d;
      mode_q     <= mode_d;
      rnd_q      <= rnd_d;
      target_q   <= target_d;
      scan_idx_q <= scan_idx_d;
      res_idx_q  <= res_idx_d;
      res_err_q  <= res_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prep_idx_d = prep_idx_q;
    prep_sum_d = prep_sum_q;
    total_d    = total_q;
    mode_d     = mode_q;
    rnd_d      = rnd_q;
    target_d   = target_q;
    scan_idx_d = scan_idx_q;
    res_idx_d  = res_idx_q;
    res_err_d  = res_err_q;
`ifdef GA_SEL_TOURNAMENT_EN
    tour_k_d   = tour_k_q;
    best_fit_d = best_fit_q;
    best_idx_d = best_idx_q;
`endif

    unique case (state_q)
      StIdle, StReady: begin
        if (wr_accept) begin
          state_d = StIdle;
        end else if (prep_start) begin
          state_d    = StPrep;
          prep_idx_d = '0;
          prep_sum_d = '0;
        end else if (state_q == StReady && req_vld) begin
          mode_d = req_mode;
          rnd_d  = req_rnd;
          if (mode_ok) begin
            res_err_d = 1'b0;
            state_d   = StTarget;
          end else begin
            res_err_d = 1'b1;
            res_idx_d = '0;
            state_d   = StResp;
          end
        end
      end
      StPrep: begin
        prep_sum_d = prep_sum_next;
        prep_idx_d = prep_idx_q + 1'b1;
        if (prep_idx_q == LastIdx) begin
          total_d = prep_sum_next;
          state_d = StReady;
        end
      end
      StTarget: begin
`ifdef GA_SEL_TOURNAMENT_EN
        if (mode_q == ModeTour) begin
          tour_k_d = '0;
          state_d  = StTour;
        end else
`endif
        if (w_total == '0) begin
          res_idx_d = rnd_q[IDX_WIDTH-1:0];
          state_d   = StResp;
        end else begin
          target_d   = prod[2*SUM_WIDTH-1:SUM_WIDTH];
          scan_idx_d = '0;
          state_d    = StScan;
        end
      end
      StScan: begin
        // t < W guarantees a hit by the last entry; the LastIdx term is only a backstop.
        if (cum_sel > target_q || scan_idx_q == LastIdx) begin
          res_idx_d = scan_idx_q;
          state_d   = StResp;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
`ifdef GA_SEL_TOURNAMENT_EN
      StTour: begin
        if (cand_wins) begin
          best_fit_d = cand_fit;
          best_idx_d = cand_idx;
        end
        if (tour_k_q == LastTour) begin
          res_idx_d = cand_wins ? cand_idx : best_idx_q;
          state_d   = StResp;
        end else begin
          tour_k_d = tour_k_q + 3'd1;
        end
      end
`endif
      StResp: begin
        if (res_rdy) state_d = StReady;
      end
      default: state_d = StIdle;
    endcase
  end

  assign req_rdy   = (state_q == StReady) && !wr_en && !prep_start;
  assign res_vld   = (state_q == StResp);
  assign prep_done = (state_q != StIdle) && (state_q != StPrep);
  assign total     = total_q;
  assign res_idx   = res_idx_q;
  assign res_err   = res_err_q;

endmodule
